// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the command, ALU-drive, response and status signals of alu_issue_ctrl.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface alu_issue_ctrl_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_a;
    logic [2:0]    cmd_b;
    logic [2:0]    cmd_sel;

    logic [2:0]    alu_a;
    logic [2:0]    alu_b;
    logic [2:0]    alu_sel;
    logic [2:0]    alu_result;
    logic          alu_carry_out;
    logic          alu_zero;
    logic          alu_equal;
    logic          alu_less_than;
    logic          alu_greater_than;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [2:0]    rsp_result;
    logic [4:0]    rsp_flags;
    logic [2:0]    rsp_sel;

    logic          sticky_carry;
    logic          clr_sticky;
    logic [CW-1:0] fifo_count;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel,
        output cmd_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_result, alu_carry_out, alu_zero, alu_equal, alu_less_than, alu_greater_than,
        output rsp_valid, rsp_result, rsp_flags, rsp_sel,
        input  rsp_ready,
        output sticky_carry,
        input  clr_sticky,
        output fifo_count
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel,
        input  cmd_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_result, alu_carry_out, alu_zero, alu_equal, alu_less_than, alu_greater_than,
        input  rsp_valid, rsp_result, rsp_flags, rsp_sel,
        output rsp_ready,
        input  sticky_carry,
        output clr_sticky,
        input  fifo_count
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Command FIFO + IDLE/EXEC/RESP sequencer that drives a 3-bit ALU from registers
// and captures its result and flags into a valid/ready response register.
module alu_issue_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    alu_issue_ctrl_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    alu_a_q, alu_a_d;
    logic [2:0]    alu_b_q, alu_b_d;
    logic [2:0]    alu_sel_q, alu_sel_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [2:0]    rsp_result_q, rsp_result_d;
    logic [4:0]    rsp_flags_q, rsp_flags_d;
    logic [2:0]    rsp_sel_q, rsp_sel_d;
    logic          sticky_q, sticky_d;

    // Entry layout: {a, b, sel}
    logic [8:0]    fifo_mem [DEPTH];
    logic [8:0]    head;
    logic          cmd_ready;
    logic          push;
    logic          pop;

    assign cmd_ready = (count_q < FULL);
    assign push      = bus.cmd_valid && cmd_ready;
    assign head      = fifo_mem[rd_ptr_q];

    // Payload storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {bus.cmd_a, bus.cmd_b, bus.cmd_sel};
        end
    end

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_sel_d    = rsp_sel_q;
        sticky_d     = sticky_q;
        pop          = 1'b0;

        if (bus.clr_sticky) begin
            sticky_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = bus.alu_result;
                rsp_flags_d  = {bus.alu_carry_out, bus.alu_zero, bus.alu_equal,
                                bus.alu_less_than, bus.alu_greater_than};
                rsp_sel_d    = alu_sel_q;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
                // A capture with carry overrides a same-edge clear.
                if (bus.alu_carry_out) begin
                    sticky_d = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pop) begin
            {alu_a_d, alu_b_d, alu_sel_d} = head;
        end
    end

    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_sel_q    <= '0;
            sticky_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_sel_q    <= rsp_sel_d;
            sticky_q     <= sticky_d;
        end
    end

    assign bus.cmd_ready    = cmd_ready;
    assign bus.alu_a        = alu_a_q;
    assign bus.alu_b        = alu_b_q;
    assign bus.alu_sel      = alu_sel_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_flags    = rsp_flags_q;
    assign bus.rsp_sel      = rsp_sel_q;
    assign bus.sticky_carry = sticky_q;
    assign bus.fifo_count   = count_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 3-bit ALU attached to its drive outputs.
module tb_alu_issue_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    alu_issue_ctrl_if #(.DEPTH(4)) bus ();

    alu_issue_ctrl #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: compare ops yield result 0 and never raise zero.
    logic [2:0] m_res;
    logic       m_c, m_z, m_e, m_l, m_g;
    always_comb begin
        m_res = 3'd0;
        m_c = 1'b0; m_e = 1'b0; m_l = 1'b0; m_g = 1'b0;
        case (bus.alu_sel)
            3'd0: m_res = bus.alu_a ^ bus.alu_b;
            3'd1: {m_c, m_res} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            3'd2: begin m_res = bus.alu_a - bus.alu_b; m_c = (bus.alu_a < bus.alu_b); end
            3'd3: m_res = bus.alu_a & bus.alu_b;
            3'd4: m_res = bus.alu_a | bus.alu_b;
            3'd5: m_e = (bus.alu_a == bus.alu_b);
            3'd6: m_l = (bus.alu_a < bus.alu_b);
            default: m_g = (bus.alu_a > bus.alu_b);
        endcase
        m_z = (bus.alu_sel < 3'd5) && (m_res == 3'd0);
    end
    assign bus.alu_result       = m_res;
    assign bus.alu_carry_out    = m_c;
    assign bus.alu_zero         = m_z;
    assign bus.alu_equal        = m_e;
    assign bus.alu_less_than    = m_l;
    assign bus.alu_greater_than = m_g;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] a, input logic [2:0] b, input logic [2:0] sel);
        bus.cmd_valid = 1'b1;
        bus.cmd_a = a; bus.cmd_b = b; bus.cmd_sel = sel;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check(tag, bus.rsp_valid, 1);
    endtask

    task automatic accept();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    logic [2:0] log_res [16];
    logic [4:0] log_flg [16];
    int         got;

    task automatic drain(input int n);
        int guard = 0;
        got = 0;
        bus.rsp_ready = 1'b1;
        while (got < n && guard < 80) begin
            if (bus.rsp_valid) begin
                log_res[got] = bus.rsp_result;
                log_flg[got] = bus.rsp_flags;
                got++;
            end
            tick();
            guard++;
        end
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [2:0] bp_exp [5];
    logic [2:0] sp_exp [3];
    logic [2:0] wr_exp [10];
    int         stale;

    initial begin
        n_cmp = 0; n_err = 0;
        bp_exp = '{3'd3, 3'd6, 3'd0, 3'd6, 3'd5};
        sp_exp = '{3'd5, 3'd0, 3'd2};
        wr_exp = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2};
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_sel = '0;
        bus.rsp_ready = 1'b0; bus.clr_sticky = 1'b0;
        tick(); tick();
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_count", bus.fifo_count, 0);
        check("rst_sticky", bus.sticky_carry, 0);
        check("rst_alu_sel", bus.alu_sel, 0);
        rst = 1'b0;
        tick();

        // ADD 5+4: latency and capture
        send(3'd5, 3'd4, 3'd1);
        check("add_cnt_e0", bus.fifo_count, 1);
        tick();
        check("add_pop_a", bus.alu_a, 5);
        check("add_pop_b", bus.alu_b, 4);
        check("add_pop_sel", bus.alu_sel, 1);
        check("add_valid_e1", bus.rsp_valid, 0);
        tick();
        check("add_valid_e2", bus.rsp_valid, 1);
        check("add_result", bus.rsp_result, 1);
        check("add_flags", bus.rsp_flags, 5'b10000);
        check("add_sel", bus.rsp_sel, 1);
        check("add_sticky", bus.sticky_carry, 1);
        tick();
        check("add_hold", bus.rsp_result, 1);
        accept();
        check("add_done", bus.rsp_valid, 0);

        // SUB 2-3 borrows
        send(3'd2, 3'd3, 3'd2);
        wait_rsp("sub_to");
        check("sub_result", bus.rsp_result, 7);
        check("sub_flags", bus.rsp_flags, 5'b10000);
        accept();

        // clear alone, then clear colliding with a carry capture
        bus.clr_sticky = 1'b1;
        tick();
        bus.clr_sticky = 1'b0;
        check("clr_alone", bus.sticky_carry, 0);
        send(3'd7, 3'd1, 3'd1);
        tick();
        bus.clr_sticky = 1'b1;
        tick();
        bus.clr_sticky = 1'b0;
        check("clr_vs_set", bus.sticky_carry, 1);
        check("add8_flags", bus.rsp_flags, 5'b11000);
        accept();

        // EQ 3==3
        send(3'd3, 3'd3, 3'd5);
        wait_rsp("eq_to");
        check("eq_result", bus.rsp_result, 0);
        check("eq_flags", bus.rsp_flags, 5'b00100);
        check("eq_sel", bus.rsp_sel, 5);
        accept();

        // Backpressure: five XORs fill RESP + FIFO, sixth is held off
        send(3'd1, 3'd2, 3'd0);
        send(3'd7, 3'd1, 3'd0);
        send(3'd5, 3'd5, 3'd0);
        send(3'd4, 3'd2, 3'd0);
        send(3'd3, 3'd6, 3'd0);
        check("bp_count", bus.fifo_count, 4);
        check("bp_ready", bus.cmd_ready, 0);
        check("bp_rsp", bus.rsp_result, 3);
        bus.cmd_valid = 1'b1; bus.cmd_a = 3'd6; bus.cmd_b = 3'd6; bus.cmd_sel = 3'd0;
        tick(); tick();
        bus.cmd_valid = 1'b0;
        check("bp_held_count", bus.fifo_count, 4);
        drain(5);
        check("bp_drained", got, 5);
        for (int i = 0; i < 5; i++) check($sformatf("bp_res%0d", i), log_res[i], bp_exp[i]);
        check("bp_zero_flag", log_flg[2], 5'b01000);
        check("bp_end_count", bus.fifo_count, 0);

        // Same-edge push and pop at count 2
        send(3'd6, 3'd3, 3'd3);
        send(3'd4, 3'd1, 3'd4);
        send(3'd5, 3'd2, 3'd3);
        check("sp_count_pre", bus.fifo_count, 2);
        check("sp_first", bus.rsp_result, 2);
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1; bus.cmd_a = 3'd2; bus.cmd_b = 3'd2; bus.cmd_sel = 3'd4;
        tick();
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        check("sp_count", bus.fifo_count, 2);
        drain(3);
        check("sp_drained", got, 3);
        for (int i = 0; i < 3; i++) check($sformatf("sp_res%0d", i), log_res[i], sp_exp[i]);

        // Pointer wrap: ten XORs streamed against a free-running consumer
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    logic rdy;
                    int   g;
                    g = 0;
                    bus.cmd_valid = 1'b1;
                    bus.cmd_a = 3'(i); bus.cmd_b = 3'd3; bus.cmd_sel = 3'd0;
                    do begin
                        rdy = bus.cmd_ready;
                        tick();
                        g++;
                    end while (!rdy && g < 30);
                end
                bus.cmd_valid = 1'b0;
            end
            drain(10);
        join
        check("wrap_drained", got, 10);
        for (int i = 0; i < 10; i++) check($sformatf("wrap_res%0d", i), log_res[i], wr_exp[i]);

        // Reset in RESP with three queued
        send(3'd7, 3'd7, 3'd1);
        send(3'd1, 3'd1, 3'd1);
        send(3'd2, 3'd1, 3'd1);
        send(3'd3, 3'd1, 3'd1);
        check("mr_count_pre", bus.fifo_count, 3);
        check("mr_valid_pre", bus.rsp_valid, 1);
        check("mr_sticky_pre", bus.sticky_carry, 1);
        #3 rst = 1'b1;
        #1;
        check("mr_valid", bus.rsp_valid, 0);
        check("mr_count", bus.fifo_count, 0);
        check("mr_cmd_ready", bus.cmd_ready, 1);
        check("mr_result", bus.rsp_result, 0);
        check("mr_flags", bus.rsp_flags, 0);
        check("mr_sel", bus.rsp_sel, 0);
        check("mr_alu", {bus.alu_a, bus.alu_b, bus.alu_sel}, 0);
        check("mr_sticky", bus.sticky_carry, 0);
        tick();
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.rsp_valid || bus.fifo_count != 0) stale++;
        end
        bus.rsp_ready = 1'b0;
        check("mr_no_stale", stale, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Command sequencer that sits directly upstream of the 3-bit ALU and also captures what it produces. It buffers (A, B, sel) commands in a small FIFO and drives the ALU operand/select inputs from registers. One ALU cycle later it latches the ALU result and status flags into a response register with a valid/ready handshake. It also keeps a sticky carry/borrow flag for software polling.

## Interface
- DEPTH, 4, command FIFO depth; power of 2, minimum 2
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept; equals (count < DEPTH)
- cmd_a, cmd_b  in  3 each  operands
- cmd_sel  in  3  opcode: 0 XOR, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 EQ, 6 LT, 7 GT
- alu_a, alu_b, alu_sel  out  3 each  registered drive to the ALU
- alu_result  in  3  ALU result
- alu_carry_out, alu_zero, alu_equal, alu_less_than, alu_greater_than  in  1 each  ALU flags
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts the response
- rsp_result  out  3  captured result
- rsp_flags  out  5  captured {carry_out, zero, equal, less_than, greater_than}
- rsp_sel  out  3  opcode of the captured response
- sticky_carry  out  1  set by any captured carry_out = 1
- clr_sticky  in  1  synchronous clear of sticky_carry
- fifo_count  out  log2(DEPTH)+1  current FIFO occupancy

## Operation
- Push: a command enters the FIFO on any edge with cmd_valid && cmd_ready. When the FIFO is full, cmd_ready = 0 and cmd_valid is ignored.
- Pop: only the FSM pops, and only when count > 0. There is no empty-FIFO bypass.
- Push and pop in the same cycle: count is unchanged; pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if count > 0, pop the head into alu_a/alu_b/alu_sel and go to EXEC; otherwise stay.
  - EXEC: the ALU settles combinationally. At the edge, capture alu_result, the flags and alu_sel into the rsp_* registers, set rsp_valid, go to RESP.
  - RESP: hold rsp_* stable while rsp_valid && !rsp_ready. On rsp_ready:
    - if count > 0, pop the next command into the alu_* registers, clear rsp_valid and go to EXEC;
    - otherwise clear rsp_valid and go to IDLE.
- alu_a/alu_b/alu_sel change only on a pop and hold their value otherwise.
- Captured values pass through unmodified; the block performs no arithmetic. Widths are exactly 3 bits and no extension is applied.
- sticky_carry:
  - set on the EXEC capture edge when alu_carry_out = 1;
  - cleared by clr_sticky;
  - if set and clear occur on the same edge, set wins.
- Reset (async, at any time, including mid-operation):
  - state = IDLE, FIFO emptied (pointers and count = 0);
  - cmd_ready = 1, rsp_valid = 0;
  - rsp_result, rsp_flags, rsp_sel, alu_a, alu_b, alu_sel = 0;
  - sticky_carry = 0.
- Commands queued or in flight at reset are discarded; no response is produced for them.

## Timing
- Latency: a command accepted at edge E0 into an empty FIFO with the FSM in IDLE is popped at E1. rsp_valid is high after E2, so the response appears 2 cycles after acceptance.
- Back-to-back throughput with rsp_ready held at 1: one response every 2 cycles (EXEC, RESP, EXEC, ...).
- rsp_* registers are stable from the rise of rsp_valid until the handshake edge.
- cmd_ready is a pure function of registered count, with no combinational path from cmd_valid or rsp_ready.
- Total buffering is DEPTH queued commands plus one in EXEC/RESP.

## Test plan
- Reset then ADD A=5, B=4:
  - rsp_valid rises 2 cycles after acceptance;
  - rsp_result = 1, rsp_flags = 5'b10000, rsp_sel = 1;
  - sticky_carry = 1.
- SUB A=2, B=3 → rsp_result = 7, carry = 1. Then EQ A=3, B=3 → rsp_result = 0, rsp_flags = 5'b00100 (zero stays 0 for compare ops).
- Backpressure, rsp_ready = 0, push 6 XOR commands:
  - the first reaches RESP;
  - the next 4 fill the FIFO, fifo_count = 4, cmd_ready = 0;
  - the 6th is held off.
  - Releasing rsp_ready drains all five in order with correct results.
- Same-edge push and pop at count = 2 → count stays 2. Pointer wrap across more than 2×DEPTH commands preserves ordering.
- clr_sticky asserted on the same edge as a carry capture → sticky_carry remains 1. clr_sticky alone → sticky_carry = 0 next cycle.
- Assert rst during RESP with 3 commands queued:
  - all outputs go immediately to their reset values and fifo_count = 0;
  - no stale response appears after rst is released.
